// File: rtl/vga_pixel_fetch_if.sv
// rtl/vga_pixel_fetch_if.sv - memory read and pixel pop bus of the VGA pixel fetcher
interface vga_pixel_fetch_if;
  logic [14:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        pix_rd;
  logic [7:0]  pix_data;
  logic        pix_valid;

  modport master (
    output mem_addr, mem_req, pix_data, pix_valid,
    input  mem_ack, mem_data, pix_rd
  );

  modport slave (
    input  mem_addr, mem_req, pix_data, pix_valid,
    output mem_ack, mem_data, pix_rd
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - line fetcher feeding a 16-word FIFO of rrr_ggg_bb pixels (option: VGA_PIXEL_FETCH_LINE_DOUBLE_EN)
module vga_pixel_fetch (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              line_start,
  vga_pixel_fetch_if.master bus,
  output logic              underflow
);
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_REQ        = 2'd1;
  localparam logic [1:0] ST_WAIT_SPACE = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;
  localparam logic [7:0] LAST_WORD     = 8'd159;
  localparam logic [7:0] LAST_SRC_LINE = 8'd199;
  localparam logic [4:0] FIFO_DEPTH    = 5'd16;

  logic [1:0]  state;
  logic [7:0]  src_line;
  logic [7:0]  start_line;
  logic [7:0]  next_src_line;
  logic [14:0] start_base;
  logic [7:0]  word_idx;
  logic [14:0] line_base;
  logic        mem_req_q;
  logic [14:0] mem_addr_q;
  logic        discard;
  logic [15:0] fifo_mem [16];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic [4:0]  count;
  logic        byte_sel;
  logic [15:0] head;
  logic        fifo_empty;
  logic        abort;
  logic        ack_take;
  logic        wr_en;
  logic        pop;
  logic        pop_word;
  logic        raise;
`ifdef VGA_PIXEL_FETCH_LINE_DOUBLE_EN
  logic        line_half;
  logic        cur_half;
`endif

  // frame_start takes effect first, so a coincident line_start fetches line 0
  always_comb begin
    start_line    = frame_start ? 8'd0 : src_line;
    next_src_line = (start_line == LAST_SRC_LINE) ? 8'd0 : start_line + 8'd1;
    start_base    = {start_line, 7'b0} + {2'b0, start_line, 5'b0};
    fifo_empty    = (count == 5'd0);
    abort         = line_start && (state == ST_REQ || state == ST_WAIT_SPACE);
    ack_take      = bus.mem_ack && mem_req_q;
    wr_en         = ack_take && !abort;
    pop           = enable && bus.pix_rd && !fifo_empty;
    pop_word      = pop && byte_sel;
    raise         = (state == ST_REQ) && !mem_req_q && !discard && enable &&
                    (count < FIFO_DEPTH);
    head          = fifo_mem[rd_ptr];
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = fifo_empty ? 8'h00 : (byte_sel ? head[7:0] : head[15:8]);

  // fetch FSM: one outstanding read at a time; an aborted read is drained and dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      word_idx   <= 8'd0;
      line_base  <= 15'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 15'd0;
      discard    <= 1'b0;
    end else if (line_start) begin
      state     <= ST_REQ;
      word_idx  <= 8'd0;
      line_base <= start_base;
      mem_req_q <= 1'b0;
      discard   <= (discard || mem_req_q) && !bus.mem_ack;
    end else begin
      discard <= discard && !bus.mem_ack;
      case (state)
        ST_REQ: begin
          if (ack_take) begin
            mem_req_q <= 1'b0;
            if (word_idx == LAST_WORD) state <= ST_DONE;
            else word_idx <= word_idx + 8'd1;
          end else if (raise) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= line_base + {7'b0, word_idx};
          end else if (!mem_req_q && !discard && count == FIFO_DEPTH) begin
            state <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: if (count < FIFO_DEPTH) state <= ST_REQ;
        default: ;
      endcase
    end
  end

  // source line counter, advanced as each line fetch is launched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_line <= 8'd0;
`ifdef VGA_PIXEL_FETCH_LINE_DOUBLE_EN
      line_half <= 1'b0;
`endif
    end else if (line_start) begin
`ifdef VGA_PIXEL_FETCH_LINE_DOUBLE_EN
      line_half <= !cur_half;
      src_line  <= cur_half ? next_src_line : start_line;
`else
      src_line <= next_src_line;
`endif
    end else if (frame_start) begin
      src_line <= 8'd0;
`ifdef VGA_PIXEL_FETCH_LINE_DOUBLE_EN
      line_half <= 1'b0;
`endif
    end
  end

`ifdef VGA_PIXEL_FETCH_LINE_DOUBLE_EN
  // first or second display line of the current source line
  always_comb cur_half = frame_start ? 1'b0 : line_half;
`endif

  // sticky underflow, cleared only at frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) underflow <= 1'b0;
    else if (frame_start) underflow <= 1'b0;
    else if (enable && bus.pix_rd && fifo_empty) underflow <= 1'b1;
  end

  // FIFO pointers and occupancy; write and pop in one cycle net out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      count    <= 5'd0;
      byte_sel <= 1'b0;
    end else if (abort) begin
      wr_ptr   <= 4'd0;
      rd_ptr   <= 4'd0;
      count    <= 5'd0;
      byte_sel <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 4'd1;
      if (pop) byte_sel <= !byte_sel;
      if (pop_word) rd_ptr <= rd_ptr + 4'd1;
      count <= count + {4'b0, wr_en} - {4'b0, pop_word};
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= bus.mem_data;
  end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - scoreboard bench for vga_pixel_fetch
module tb_vga_pixel_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic frame_start = 1'b0;
  logic line_start = 1'b0;
  logic underflow;

  vga_pixel_fetch_if bus ();

  vga_pixel_fetch dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .line_start(line_start), .bus(bus), .underflow(underflow)
  );

`ifdef VGA_PIXEL_FETCH_LINE_DOUBLE_EN
  localparam int DBL = 1;
`else
  localparam int DBL = 0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0]  exp_q [$];
  logic [14:0] ack_log [$];
  int ack_cnt = 0;
  int slow_at = -1;
  bit slow_pending = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [14:0] a);
    return 16'hA1B2 + 16'(a) * 16'h0101;
  endfunction

  // memory model: ack after a latency, slow (and unscored) for the chosen index
  initial begin
    logic [14:0] a;
    logic [15:0] d;
    bit slow;
    bus.mem_ack = 1'b0;
    bus.mem_data = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        a = bus.mem_addr;
        slow = (ack_cnt == slow_at);
        if (slow) begin
          slow_pending = 1;
          repeat (4) @(posedge clk);
          #1;
        end
        d = word_of(a);
        bus.mem_ack = 1'b1;
        bus.mem_data = d;
        ack_log.push_back(a);
        ack_cnt++;
        if (slow) slow_pending = 0;
        else begin
          exp_q.push_back(d[15:8]);
          exp_q.push_back(d[7:0]);
        end
      end
    end
  end

  task automatic pulse(input bit fs, input bit ls);
    @(negedge clk);
    frame_start = fs;
    line_start = ls;
    @(negedge clk);
    frame_start = 1'b0;
    line_start = 1'b0;
  endtask

  task automatic pop_n(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.pix_valid) begin
        if (exp_q.size() == 0) check_eq("extra_pixel", 32'(bus.pix_data), 32'hFFFF);
        else check_eq("pix_data", 32'(bus.pix_data), 32'(exp_q.pop_front()));
        bus.pix_rd = 1'b1;
        got++;
      end else begin
        bus.pix_rd = 1'b0;
      end
    end
    @(negedge clk);
    bus.pix_rd = 1'b0;
    if (got < n) check_eq("pop_timeout", 32'(got), 32'(n));
  endtask

  task automatic wait_acks(input int target, input int budget, input string tag);
    int cyc = 0;
    while (ack_cnt < target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (ack_cnt < target) check_eq(tag, 32'(ack_cnt), 32'(target));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cyc;
    bus.pix_rd = 1'b0;

    // reset state
    #1;
    check_eq("rst_mem_req", 32'(bus.mem_req), 0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 0);
    check_eq("rst_pix_valid", 32'(bus.pix_valid), 0);
    check_eq("rst_pix_data", 32'(bus.pix_data), 0);
    check_eq("rst_underflow", 32'(underflow), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // underflow on empty pop, sticky until frame_start
    pulse(1, 0);
    @(negedge clk);
    bus.pix_rd = 1'b1;
    #1;
    check_eq("uf_pix_data", 32'(bus.pix_data), 0);
    @(negedge clk);
    bus.pix_rd = 1'b0;
    check_eq("uf_set", 32'(underflow), 1);
    repeat (5) @(negedge clk);
    check_eq("uf_sticky", 32'(underflow), 1);
    check_eq("uf_still_empty", 32'(bus.pix_valid), 0);
    pulse(1, 0);
    check_eq("uf_cleared", 32'(underflow), 0);

    // full line: addresses 0..159, pixels A1,B2,...
    base = ack_cnt;
    pulse(1, 1);
    pop_n(320, 3000);
    repeat (10) @(negedge clk);
    check_eq("line_ack_count", 32'(ack_cnt - base), 160);
    check_eq("line_done_req", 32'(bus.mem_req), 0);
    check_eq("line_done_empty", 32'(bus.pix_valid), 0);
    for (int i = 0; i < 160; i++) check_eq("line_addr", 32'(ack_log[base + i]), 32'(i));

    // backpressure: 16 requests, then one more per freed word
    exp_q.delete();
    base = ack_cnt;
    pulse(1, 1);
    repeat (60) @(negedge clk);
    check_eq("full_acks", 32'(ack_cnt - base), 16);
    check_eq("full_req_low", 32'(bus.mem_req), 0);
    check_eq("full_valid", 32'(bus.pix_valid), 1);
    pop_n(2, 10);
    repeat (10) @(negedge clk);
    check_eq("refill_acks", 32'(ack_cnt - base), 17);
    check_eq("refill_req_low", 32'(bus.mem_req), 0);

    // abort at word 40 with a read outstanding
    base = ack_cnt;
    slow_at = base + 40;
    pulse(1, 1);
    exp_q.delete();
    fork
      pop_n(80, 2000);
      begin
        cyc = 0;
        while (!slow_pending && cyc < 2000) begin
          @(negedge clk);
          cyc++;
        end
        check_eq("slow_seen", 32'(slow_pending), 1);
      end
    join
    slow_at = -1;
    check_eq("abort_pre_empty", 32'(bus.pix_valid), 0);
    pulse(0, 1);
    exp_q.delete();
    check_eq("abort_req_low", 32'(bus.mem_req), 0);
    check_eq("abort_flushed", 32'(bus.pix_valid), 0);
    wait_acks(base + 42, 50, "abort_acks");
    if (ack_cnt >= base + 42) begin
      check_eq("abort_addr40", 32'(ack_log[base + 40]), 40);
      check_eq("abort_next_addr", 32'(ack_log[base + 41]), 160);
    end
    pop_n(2, 20);

    // line base addresses and wrap after the last source line
    pulse(1, 0);
    for (int k = 0; k <= 200 * (DBL + 1); k++) begin
      pulse(0, 1);
      exp_q.delete();
      base = ack_cnt;
      wait_acks(base + 1, 20, "base_ack");
      if (ack_cnt > base)
        check_eq("line_base", 32'(ack_log[base]), 32'(((k >> DBL) % 200) * 160));
    end

    // reset during an outstanding read; the late ack is ignored
    pulse(1, 1);
    exp_q.delete();
    slow_at = ack_cnt;
    cyc = 0;
    while (!slow_pending && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_slow_seen", 32'(slow_pending), 1);
    slow_at = -1;
    reset = 1'b1;
    #1;
    check_eq("rst2_mem_req", 32'(bus.mem_req), 0);
    check_eq("rst2_mem_addr", 32'(bus.mem_addr), 0);
    check_eq("rst2_pix_valid", 32'(bus.pix_valid), 0);
    check_eq("rst2_pix_data", 32'(bus.pix_data), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    while (slow_pending && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check_eq("rst2_stale_ignored", 32'(bus.pix_valid), 0);
    check_eq("rst2_idle_req", 32'(bus.mem_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
